// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master: FSM state encoding, idle levels of
// the serial lines and a small helper that tells whether the serial clock
// generator should be running in a given state.
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_RESP  = 3'd4
    } spi_state_e;

    localparam logic SCK_IDLE  = 1'b0;
    localparam logic MOSI_IDLE = 1'b1;
    localparam logic SS_IDLE   = 1'b1;

    // The divider runs while the frame is open (ss_n low).
    function automatic logic frame_active(input spi_state_e st);
        logic act;
        case (st)
            ST_SETUP: act = 1'b1;
            ST_XFER:  act = 1'b1;
            ST_HOLD:  act = 1'b1;
            default:  act = 1'b0;
        endcase
        return act;
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// -----------------------------------------------------------------------------
// spi_clkgen
// Serial clock divider. Counts DIV clk cycles per sck half-period while
// enabled and toggles sck at the end of each half-period when toggling is
// allowed. Disabled, it parks the counter at 0 and sck at its idle level.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   en_i          run the half-period counter
//   toggle_en_i   allow sck to toggle at the end of a half-period
//   sck_o         registered serial clock level
//   tick_o        last cycle of the current half-period
//   rise_o        first cycle in which sck is high (sampling cycle)
//   fall_o        last cycle of a high phase; sck falls at the next edge
// -----------------------------------------------------------------------------
module spi_clkgen
    import spi_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic toggle_en_i,
    output logic sck_o,
    output logic tick_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sck_q, sck_d;
    logic             tick_s;

    assign tick_s = en_i && (cnt_q == CNT_LAST);

    // Next-state logic for the half-period counter and the sck level.
    always_comb begin
        cnt_d = cnt_q;
        sck_d = sck_q;
        if (!en_i) begin
            cnt_d = '0;
            sck_d = SCK_IDLE;
        end else if (tick_s) begin
            cnt_d = '0;
            if (toggle_en_i) begin
                sck_d = ~sck_q;
            end else begin
                sck_d = sck_q;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sck_q <= SCK_IDLE;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    assign sck_o  = sck_q;
    assign tick_o = tick_s;
    assign rise_o = en_i && sck_q && (cnt_q == '0);
    assign fall_o = tick_s && toggle_en_i && sck_q;

endmodule

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
// SPI master (mode 0: sck idles low, sample on rising, shift on falling).
// Accepts a request over a valid/ready handshake, frames it with ss_n, shifts
// up to MAX_LEN bits out on mosi while capturing miso, and returns the
// received word over a valid/ready response channel.
//
// Ports:
//   clk, rst_n                 system clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_data, req_len          transmit bits (right-aligned) and bit count
//   req_lsb_first              1: bit 0 first, 0: bit len-1 first
//   rsp_valid/rsp_ready        response handshake
//   rsp_data                   received bits, right-aligned, upper bits zero
//   sck, ss_n, mosi, miso      SPI bus
// -----------------------------------------------------------------------------
module spi_master
    import spi_pkg::*;
#(
    parameter int MAX_LEN = 64,
    parameter int DIV     = 2,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [MAX_LEN-1:0] req_data,
    input  logic [LEN_W-1:0]   req_len,
    input  logic               req_lsb_first,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               sck,
    output logic               ss_n,
    output logic               mosi,
    input  logic               miso
);

    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int GAP_W = $clog2(DIV + 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(DIV);

    spi_state_e         state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               lsb_q, lsb_d;
    logic [LEN_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [MAX_LEN-1:0] tx_q, tx_d;
    logic [MAX_LEN-1:0] rx_q, rx_d;
    logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               req_ready_q, req_ready_d;
    logic               ss_n_q, ss_n_d;
    logic               mosi_q, mosi_d;
    logic [GAP_W-1:0]   gap_q, gap_d;

    logic               handshake_s;
    logic               last_bit_s;
    logic [LEN_W-1:0]   len_clamp_s;
    logic [MAX_LEN-1:0] tx_align_s;
    logic [MAX_LEN-1:0] tx_shift_s;
    logic               tx_head_s;
    logic [IDX_W-1:0]   rx_pos_s;
    logic               sck_s, tick_s, rise_s, fall_s;

    spi_clkgen #(.DIV(DIV)) u_clkgen (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (frame_active(state_q)),
        .toggle_en_i ((state_q == ST_SETUP) || (state_q == ST_XFER)),
        .sck_o       (sck_s),
        .tick_o      (tick_s),
        .rise_o      (rise_s),
        .fall_o      (fall_s)
    );

    assign handshake_s = req_valid && req_ready_q;
    assign last_bit_s  = (bit_cnt_q == (len_q - LEN_W'(1)));

    // Request decode and shift-register helpers.
    always_comb begin
        if (req_len > LEN_MAX) begin
            len_clamp_s = LEN_MAX;
        end else begin
            len_clamp_s = req_len;
        end
        // MSB-first frames are pre-aligned so the first bit sits at the top.
        if (req_lsb_first) begin
            tx_align_s = req_data;
        end else begin
            tx_align_s = req_data << (LEN_MAX - len_clamp_s);
        end
        if (lsb_q) begin
            tx_shift_s = {1'b0, tx_q[MAX_LEN-1:1]};
            tx_head_s  = tx_shift_s[0];
            rx_pos_s   = bit_cnt_q[IDX_W-1:0];
        end else begin
            tx_shift_s = {tx_q[MAX_LEN-2:0], 1'b0};
            tx_head_s  = tx_shift_s[MAX_LEN-1];
            // Modulo arithmetic keeps len = MAX_LEN correct in IDX_W bits.
            rx_pos_s   = len_q[IDX_W-1:0] - IDX_W'(1) - bit_cnt_q[IDX_W-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (handshake_s) begin
                    state_d = (len_clamp_s == '0) ? ST_RESP : ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: state_d = tick_s ? ST_XFER : ST_SETUP;
            ST_XFER:  state_d = (fall_s && last_bit_s) ? ST_HOLD : ST_XFER;
            ST_HOLD:  state_d = tick_s ? ST_RESP : ST_HOLD;
            ST_RESP:  state_d = rsp_ready ? ST_IDLE : ST_RESP;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM output / datapath next-value logic.
    always_comb begin
        len_d       = len_q;
        lsb_d       = lsb_q;
        bit_cnt_d   = bit_cnt_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        ss_n_d      = ss_n_q;
        mosi_d      = mosi_q;
        gap_d       = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end else begin
                    gap_d = gap_q;
                end
                if (handshake_s) begin
                    len_d     = len_clamp_s;
                    lsb_d     = req_lsb_first;
                    bit_cnt_d = '0;
                    rx_d      = '0;
                    tx_d      = tx_align_s;
                    if (len_clamp_s == '0) begin
                        rsp_data_d  = '0;
                        rsp_valid_d = 1'b1;
                    end else begin
                        ss_n_d = 1'b0;
                        mosi_d = req_lsb_first ? tx_align_s[0] : tx_align_s[MAX_LEN-1];
                    end
                end else begin
                    len_d = len_q;
                end
            end
            ST_XFER: begin
                if (rise_s) begin
                    rx_d[rx_pos_s] = miso;
                end else begin
                    rx_d = rx_q;
                end
                if (fall_s) begin
                    bit_cnt_d = bit_cnt_q + LEN_W'(1);
                    if (!last_bit_s) begin
                        tx_d   = tx_shift_s;
                        mosi_d = tx_head_s;
                    end else begin
                        tx_d = tx_q;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
            end
            ST_HOLD: begin
                if (tick_s) begin
                    ss_n_d      = SS_IDLE;
                    mosi_d      = MOSI_IDLE;
                    rsp_data_d  = rx_q;
                    rsp_valid_d = 1'b1;
                end else begin
                    ss_n_d = ss_n_q;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    gap_d       = GAP_LOAD;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                ss_n_d = ss_n_q;
            end
        endcase
        req_ready_d = (state_d == ST_IDLE) && (gap_d == '0);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q       <= '0;
            lsb_q       <= 1'b0;
            bit_cnt_q   <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            ss_n_q      <= SS_IDLE;
            mosi_q      <= MOSI_IDLE;
            gap_q       <= '0;
        end else begin
            len_q       <= len_d;
            lsb_q       <= lsb_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            gap_q       <= gap_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign sck       = sck_s;
    assign ss_n      = ss_n_q;
    assign mosi      = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
// Directed self-checking bench for spi_master (MAX_LEN=64, DIV=2).
// miso is either looped back from mosi or driven to a constant level.
// -----------------------------------------------------------------------------
module tb_spi_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_data;
    logic [6:0]  req_len;
    logic        req_lsb_first;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        sck;
    logic        ss_n;
    logic        mosi;
    logic        miso;
    logic        loopback;
    logic        miso_drv;

    int tests_run;
    int tests_failed;

    assign miso = loopback ? mosi : miso_drv;

    spi_master #(.MAX_LEN(64), .DIV(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_data      (req_data),
        .req_len       (req_len),
        .req_lsb_first (req_lsb_first),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .sck           (sck),
        .ss_n          (ss_n),
        .mosi          (mosi),
        .miso          (miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request and observe the frame until rsp_valid (not accepted).
    task automatic run_xfer(input logic [63:0] data, input logic [6:0] len, input logic lsb,
                            output logic [63:0] rsp, output int ss_low, output int rises,
                            output logic [63:0] seq, output logic first_mosi,
                            output int rsp_cyc, output bit to);
        logic prev_sck;
        int   n;
        rsp = '0; ss_low = 0; rises = 0; seq = '0; first_mosi = 1'b0;
        rsp_cyc = 0; to = 1'b0; prev_sck = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_data = data; req_len = len; req_lsb_first = lsb;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            to = 1'b1;
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        // Scramble the request inputs: they must not affect the frame.
        req_valid = 1'b0; req_data = ~data; req_len = 7'd0; req_lsb_first = ~lsb;
        for (int cyc = 1; cyc < 400; cyc++) begin
            @(negedge clk);
            if (cyc == 1) first_mosi = mosi;
            if (!ss_n) ss_low++;
            if (sck && !prev_sck) begin
                if (rises < 64) seq[rises] = mosi;
                rises++;
            end
            prev_sck = sck;
            if (rsp_valid) begin
                rsp = rsp_data;
                rsp_cyc = cyc;
                return;
            end
        end
        to = 1'b1;
    endtask

    // Accept the pending response (called at a negedge).
    task automatic accept_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests_run++; if (sck !== 1'b0) begin tests_failed++; $display("FAIL rst_sck: got %b expected 0", sck); end
        tests_run++; if (ss_n !== 1'b1) begin tests_failed++; $display("FAIL rst_ss_n: got %b expected 1", ss_n); end
        tests_run++; if (mosi !== 1'b1) begin tests_failed++; $display("FAIL rst_mosi: got %b expected 1", mosi); end
        tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_req_ready: got %b expected 1", req_ready); end
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
        tests_run++; if (rsp_data !== 64'h0) begin tests_failed++; $display("FAIL rst_rsp_data: got %h expected 0", rsp_data); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++; if (req_ready !== 1'b1 || ss_n !== 1'b1 || sck !== 1'b0) begin
            tests_failed++; $display("FAIL post_rst_idle: got ready=%b ss_n=%b sck=%b expected 1 1 0", req_ready, ss_n, sck);
        end
    endtask

    task automatic test_loop_msb();
        logic [63:0] rsp, seq; int ss_low, rises, rc; logic fm; bit to;
        loopback = 1'b1;
        run_xfer(64'hA5, 7'd8, 1'b0, rsp, ss_low, rises, seq, fm, rc, to);
        tests_run++; if (to) begin tests_failed++; $display("FAIL msb8_timeout: got timeout expected response"); end
        tests_run++; if (rsp !== 64'hA5) begin tests_failed++; $display("FAIL msb8_rsp: got %h expected a5", rsp); end
        tests_run++; if (seq !== 64'hA5) begin tests_failed++; $display("FAIL msb8_mosi_seq: got %h expected a5 (1,0,1,0,0,1,0,1)", seq); end
        tests_run++; if (fm !== 1'b1) begin tests_failed++; $display("FAIL msb8_first_mosi: got %b expected 1", fm); end
        tests_run++; if (ss_low != 34) begin tests_failed++; $display("FAIL msb8_ss_low: got %0d expected 34", ss_low); end
        tests_run++; if (rc != 35) begin tests_failed++; $display("FAIL msb8_rsp_cycle: got %0d expected 35", rc); end
        tests_run++; if (rises != 8) begin tests_failed++; $display("FAIL msb8_rises: got %0d expected 8", rises); end
        accept_rsp();
    endtask

    task automatic test_loop_lsb();
        logic [63:0] rsp, seq; int ss_low, rises, rc; logic fm; bit to;
        loopback = 1'b1;
        run_xfer(64'h3C6, 7'd12, 1'b1, rsp, ss_low, rises, seq, fm, rc, to);
        tests_run++; if (to) begin tests_failed++; $display("FAIL lsb12_timeout: got timeout expected response"); end
        tests_run++; if (rsp !== 64'h3C6) begin tests_failed++; $display("FAIL lsb12_rsp: got %h expected 3c6", rsp); end
        tests_run++; if (fm !== 1'b0) begin tests_failed++; $display("FAIL lsb12_first_mosi: got %b expected 0", fm); end
        tests_run++; if (seq !== 64'h3C6) begin tests_failed++; $display("FAIL lsb12_mosi_seq: got %h expected 3c6", seq); end
        tests_run++; if (ss_low != 50) begin tests_failed++; $display("FAIL lsb12_ss_low: got %0d expected 50", ss_low); end
        accept_rsp();
    endtask

    task automatic test_miso_high();
        logic [63:0] rsp, seq; int ss_low, rises, rc; logic fm; bit to;
        loopback = 1'b0; miso_drv = 1'b1;
        run_xfer(64'h0, 7'd5, 1'b0, rsp, ss_low, rises, seq, fm, rc, to);
        tests_run++; if (to || rsp !== 64'h1F) begin tests_failed++; $display("FAIL miso1_len5: got %h (to=%0d) expected 1f", rsp, to); end
        accept_rsp();
        run_xfer(64'h0, 7'd70, 1'b0, rsp, ss_low, rises, seq, fm, rc, to);
        tests_run++; if (to) begin tests_failed++; $display("FAIL clamp_timeout: got timeout expected response"); end
        tests_run++; if (rises != 64) begin tests_failed++; $display("FAIL clamp_rises: got %0d expected 64", rises); end
        tests_run++; if (rsp !== 64'hFFFF_FFFF_FFFF_FFFF) begin tests_failed++; $display("FAIL clamp_rsp: got %h expected all ones", rsp); end
        tests_run++; if (ss_low != 258) begin tests_failed++; $display("FAIL clamp_ss_low: got %0d expected 258", ss_low); end
        accept_rsp();
        miso_drv = 1'b0;
    endtask

    task automatic test_len_zero();
        logic [63:0] rsp, seq; int ss_low, rises, rc; logic fm; bit to;
        loopback = 1'b0; miso_drv = 1'b1;
        run_xfer(64'hFF, 7'd0, 1'b0, rsp, ss_low, rises, seq, fm, rc, to);
        tests_run++; if (to || rc != 1) begin tests_failed++; $display("FAIL len0_rsp_cycle: got %0d (to=%0d) expected 1", rc, to); end
        tests_run++; if (rsp !== 64'h0) begin tests_failed++; $display("FAIL len0_rsp: got %h expected 0", rsp); end
        tests_run++; if (ss_low != 0 || rises != 0) begin tests_failed++; $display("FAIL len0_bus: got ss_low=%0d rises=%0d expected 0 0", ss_low, rises); end
        accept_rsp();
        miso_drv = 1'b0;
    endtask

    task automatic test_stall();
        logic [63:0] rsp, seq; int ss_low, rises, rc; logic fm; bit to;
        loopback = 1'b1;
        run_xfer(64'h5A, 7'd8, 1'b0, rsp, ss_low, rises, seq, fm, rc, to);
        tests_run++; if (to || rsp !== 64'h5A) begin tests_failed++; $display("FAIL stall_rsp: got %h (to=%0d) expected 5a", rsp, to); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests_run++;
            if (rsp_valid !== 1'b1 || rsp_data !== 64'h5A || req_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: got valid=%b data=%h ready=%b expected 1 5a 0", i, rsp_valid, rsp_data, req_ready);
            end
        end
        accept_rsp();
        @(negedge clk);
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_release: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] rsp, seq; int ss_low, rises, rc; logic fm; bit to; int hi; bit seen_low;
        loopback = 1'b1;
        run_xfer(64'h9, 7'd4, 1'b1, rsp, ss_low, rises, seq, fm, rc, to);
        tests_run++; if (to || rsp !== 64'h9) begin tests_failed++; $display("FAIL b2b_a_rsp: got %h (to=%0d) expected 9", rsp, to); end
        // Accept A and present B in the same cycle.
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_data = 64'h3C; req_len = 7'd8; req_lsb_first = 1'b0;
        hi = 0; seen_low = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!ss_n) begin
                seen_low = 1'b1;
                break;
            end
            hi++;
            if (req_ready && req_valid) begin
                @(posedge clk); #1;
                req_valid = 1'b0; req_data = 64'h0;
            end else begin
                @(posedge clk); #1;
            end
            rsp_ready = 1'b0;
        end
        tests_run++; if (!seen_low || hi < 2) begin tests_failed++; $display("FAIL b2b_gap: got %0d high cycles (frame=%0d) expected >= 2", hi, seen_low); end
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                to = 1'b0;
                break;
            end
        end
        tests_run++; if (to || rsp_data !== 64'h3C) begin tests_failed++; $display("FAIL b2b_b_rsp: got %h (to=%0d) expected 3c", rsp_data, to); end
        accept_rsp();
    endtask

    task automatic test_mid_reset();
        logic [63:0] rsp, seq; int ss_low, rises, rc; logic fm; bit to; bit saw_valid; int n;
        loopback = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_data = 64'hD0; req_len = 7'd8; req_lsb_first = 1'b0;
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (11) @(negedge clk);
        // Cycle 11: rising edge 3, third bit is req_data[5] = 0.
        tests_run++; if (ss_n !== 1'b0 || sck !== 1'b1 || mosi !== 1'b0) begin
            tests_failed++; $display("FAIL mid_pre: got ss_n=%b sck=%b mosi=%b expected 0 1 0", ss_n, sck, mosi);
        end
        rst_n = 1'b0;
        #1;
        tests_run++; if (ss_n !== 1'b1 || sck !== 1'b0 || mosi !== 1'b1) begin
            tests_failed++; $display("FAIL mid_rst_bus: got ss_n=%b sck=%b mosi=%b expected 1 0 1", ss_n, sck, mosi);
        end
        tests_run++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            tests_failed++; $display("FAIL mid_rst_hs: got valid=%b ready=%b expected 0 1", rsp_valid, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) saw_valid = 1'b1;
        end
        tests_run++; if (saw_valid) begin tests_failed++; $display("FAIL mid_no_rsp: got rsp_valid=1 expected 0"); end
        run_xfer(64'h96, 7'd8, 1'b0, rsp, ss_low, rises, seq, fm, rc, to);
        tests_run++; if (to || rsp !== 64'h96 || ss_low != 34) begin
            tests_failed++; $display("FAIL mid_after: got %h ss_low=%0d (to=%0d) expected 96 34", rsp, ss_low, to);
        end
        accept_rsp();
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_data = '0; req_len = '0; req_lsb_first = 1'b0;
        rsp_ready = 1'b0; loopback = 1'b0; miso_drv = 1'b0;
        test_reset();
        test_loop_msb();
        test_loop_lsb();
        test_miso_high();
        test_len_zero();
        test_stall();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
